// File: rtl/time_setter.sv
// Time-entry editor: preloads the running time when the mode FSM enters the set state,
// edits hours/minutes/seconds field by field, and pulses commit once on completion.
module time_setter #(
  parameter logic [2:0] SET_STATE  = 3'b010,
  parameter int         NUM_FIELDS = 3,
  parameter int         HOUR_MAX   = 23,
  parameter int         MIN_MAX    = 59,
  parameter int         SEC_MAX    = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic       nxt_but,
  input  logic       load_but,
  input  logic       inc_but,
  input  logic       dec_but,
  input  logic [5:0] in_time,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] field,
  output logic       editing,
  output logic       commit
);

  // state | meaning
  // IDLE  | not in set mode; buttons ignored, edit registers hold
  // EDIT  | user edits the selected field
  // DONE  | committed; waits for the mode FSM to leave the set state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EDIT = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [5:0] HOUR_LIM   = 6'(HOUR_MAX);
  localparam logic [5:0] MIN_LIM    = 6'(MIN_MAX);
  localparam logic [5:0] SEC_LIM    = 6'(SEC_MAX);
  localparam logic [1:0] LAST_FIELD = 2'(NUM_FIELDS - 1);

  fsm_t fsm_q;

  logic nxt_q, load_q, inc_q, dec_q;
  logic nxt_edge, load_edge, inc_edge, dec_edge;
  logic in_set;

  logic [5:0] cur_val;
  logic [5:0] max_val;
  logic [5:0] act_val;
  logic       edit_hit;

  assign nxt_edge  = nxt_but  & ~nxt_q;
  assign load_edge = load_but & ~load_q;
  assign inc_edge  = inc_but  & ~inc_q;
  assign dec_edge  = dec_but  & ~dec_q;
  assign edit_hit  = load_edge | inc_edge | dec_edge;
  assign in_set    = (state == SET_STATE);

  // New value for the selected field; the load clamp compares all 6 switch bits.
  always_comb begin
    cur_val = '0;
    max_val = '0;
    case (field)
      2'd0: begin
        cur_val = {1'b0, hours};
        max_val = HOUR_LIM;
      end
      2'd1: begin
        cur_val = minutes;
        max_val = MIN_LIM;
      end
      default: begin
        cur_val = seconds;
        max_val = SEC_LIM;
      end
    endcase

    act_val = cur_val;
    if (load_edge) begin
      act_val = (in_time > max_val) ? max_val : in_time;
    end else if (inc_edge) begin
      act_val = (cur_val >= max_val) ? 6'd0 : cur_val + 6'd1;
    end else if (dec_edge) begin
      act_val = (cur_val == 6'd0) ? max_val : cur_val - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
      field   <= '0;
      editing <= 1'b0;
      commit  <= 1'b0;
      nxt_q   <= 1'b0;
      load_q  <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      nxt_q  <= nxt_but;
      load_q <= load_but;
      inc_q  <= inc_but;
      dec_q  <= dec_but;
      commit <= 1'b0;

      case (fsm_q)
        IDLE: begin
          if (in_set) begin
            fsm_q   <= EDIT;
            hours   <= cur_hours;
            minutes <= cur_minutes;
            seconds <= cur_seconds;
            field   <= '0;
            editing <= 1'b1;
          end
        end

        EDIT: begin
          if (!in_set) begin
            // Abort wins over any button edge seen on the same cycle.
            fsm_q   <= IDLE;
            editing <= 1'b0;
          end else begin
            if (edit_hit) begin
              case (field)
                2'd0:    hours   <= act_val[4:0];
                2'd1:    minutes <= act_val;
                default: seconds <= act_val;
              endcase
            end
            if (nxt_edge) begin
              if (field == LAST_FIELD) begin
                fsm_q   <= DONE;
                commit  <= 1'b1;
                editing <= 1'b0;
                if (NUM_FIELDS == 2) begin
                  seconds <= '0;
                end
              end else begin
                field <= field + 2'd1;
              end
            end
          end
        end

        DONE: begin
          if (!in_set) begin
            fsm_q <= IDLE;
          end
        end

        default: begin
          fsm_q   <= IDLE;
          editing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter: a H/M/S instance and a H/M-only instance share stimulus.
module tb_time_setter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state;
  logic       nxt_but, load_but, inc_but, dec_but;
  logic [5:0] in_time;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes, cur_seconds;

  logic [4:0] hours3, hours2;
  logic [5:0] minutes3, minutes2, seconds3, seconds2;
  logic [1:0] field3, field2;
  logic       editing3, editing2, commit3, commit2;

  int total = 0;
  int bad = 0;
  int commits3 = 0;
  int commits2 = 0;
  int base2;

  always #5 clk = ~clk;

  time_setter #(.NUM_FIELDS(3)) dut3 (
    .clk(clk), .rst(rst), .state(state),
    .nxt_but(nxt_but), .load_but(load_but), .inc_but(inc_but), .dec_but(dec_but),
    .in_time(in_time), .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .hours(hours3), .minutes(minutes3), .seconds(seconds3),
    .field(field3), .editing(editing3), .commit(commit3)
  );

  time_setter #(.NUM_FIELDS(2)) dut2 (
    .clk(clk), .rst(rst), .state(state),
    .nxt_but(nxt_but), .load_but(load_but), .inc_but(inc_but), .dec_but(dec_but),
    .in_time(in_time), .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .hours(hours2), .minutes(minutes2), .seconds(seconds2),
    .field(field2), .editing(editing2), .commit(commit2)
  );

  always @(negedge clk) begin
    if (commit3) commits3 <= commits3 + 1;
    if (commit2) commits2 <= commits2 + 1;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_buttons();
    nxt_but = 0; load_but = 0; inc_but = 0; dec_but = 0;
  endtask

  initial begin
    rst = 1; state = 3'b010; in_time = 6'd63;
    nxt_but = 1; load_but = 1; inc_but = 1; dec_but = 1;
    cur_hours = 5'd12; cur_minutes = 6'd34; cur_seconds = 6'd56;
    step();
    check_val("rst_hours",   hours3,   0);
    check_val("rst_minutes", minutes3, 0);
    check_val("rst_seconds", seconds3, 0);
    check_val("rst_field",   field3,   0);
    check_val("rst_editing", editing3, 0);
    check_val("rst_commit",  commit3,  0);

    // buttons held high across reset release must not fire
    rst = 0;
    step();
    check_val("entry_editing", editing3, 1);
    check_val("entry_hours",   hours3,   12);
    check_val("entry_minutes", minutes3, 34);
    check_val("entry_seconds", seconds3, 56);
    check_val("entry_field",   field3,   0);
    step();
    check_val("held_hours",  hours3, 12);
    check_val("held_field",  field3, 0);
    release_buttons();
    step();

    in_time = 6'd7; load_but = 1; step();
    check_val("load7_hours", hours3, 7);
    load_but = 0; step();
    in_time = 6'd40; load_but = 1; step();
    check_val("clamp40_hours", hours3, 23);
    load_but = 0; step();
    inc_but = 1; step();
    check_val("inc_wrap_hours", hours3, 0);
    inc_but = 0; step();
    inc_but = 1;
    repeat (10) step();
    check_val("inc_held_hours", hours3, 1);
    inc_but = 0; step();
    in_time = 6'd5; load_but = 1; inc_but = 1; step();
    check_val("load_beats_inc", hours3, 5);
    release_buttons(); step();
    in_time = 6'd9; load_but = 1; step();
    check_val("load9_hours", hours3, 9);
    load_but = 0; step();

    nxt_but = 1; step();
    check_val("nxt_field1", field3, 1);
    check_val("nxt_hours_kept", hours3, 9);
    nxt_but = 0; step();
    in_time = 6'd63; load_but = 1; step();
    check_val("clamp63_minutes", minutes3, 59);
    load_but = 0; step();
    in_time = 6'd0; load_but = 1; step();
    load_but = 0; step();
    dec_but = 1; step();
    check_val("dec_wrap_minutes", minutes3, 59);
    dec_but = 0; step();
    in_time = 6'd30; load_but = 1; nxt_but = 1; step();
    check_val("load_nxt_minutes", minutes3, 30);
    check_val("load_nxt_field",   field3,   2);
    release_buttons(); step();
    in_time = 6'd15; load_but = 1; step();
    check_val("load15_seconds", seconds3, 15);
    load_but = 0; step();

    nxt_but = 1; step();
    check_val("done_commit",  commit3,  1);
    check_val("done_editing", editing3, 0);
    check_val("done_hours",   hours3,   9);
    check_val("done_minutes", minutes3, 30);
    check_val("done_seconds", seconds3, 15);
    nxt_but = 0; step();
    check_val("commit_one_cycle", commit3, 0);
    repeat (20) step();
    check_val("single_commit", commits3, 1);
    check_val("done_stays_idle", editing3, 0);

    state = 3'b000; step();
    check_val("leave_hours_hold", hours3, 9);
    cur_hours = 5'd1; cur_minutes = 6'd2; cur_seconds = 6'd3;
    state = 3'b010; step();
    check_val("reentry_editing", editing3, 1);
    check_val("reentry_hours",   hours3,   1);
    check_val("reentry_minutes", minutes3, 2);
    check_val("reentry_seconds", seconds3, 3);
    check_val("reentry_field",   field3,   0);

    nxt_but = 1; step();
    nxt_but = 0; step();
    state = 3'b000; nxt_but = 1; step();
    check_val("abort_editing", editing3, 0);
    check_val("abort_field",   field3,   1);
    check_val("abort_commit",  commit3,  0);
    nxt_but = 0; inc_but = 1; step();
    check_val("idle_ignores_inc", hours3, 1);
    inc_but = 0; step(); step();
    check_val("abort_no_commit", commits3, 1);

    state = 3'b010; step();
    inc_but = 1; step();
    check_val("preabort_inc_hours", hours3, 2);
    inc_but = 0; rst = 1; step();
    check_val("midrst_hours",   hours3,   0);
    check_val("midrst_minutes", minutes3, 0);
    check_val("midrst_seconds", seconds3, 0);
    check_val("midrst_field",   field3,   0);
    check_val("midrst_editing", editing3, 0);
    check_val("midrst_commit",  commits3, 1);

    // H/M-only instance
    rst = 0; base2 = commits2; step();
    check_val("hm_entry_editing", editing2, 1);
    check_val("hm_entry_seconds", seconds2, 3);
    nxt_but = 1; step();
    check_val("hm_field1", field2, 1);
    nxt_but = 0; step();
    in_time = 6'd45; load_but = 1; step();
    check_val("hm_load45", minutes2, 45);
    load_but = 0; step();
    nxt_but = 1; step();
    check_val("hm_commit",  commit2,  1);
    check_val("hm_seconds", seconds2, 0);
    check_val("hm_minutes", minutes2, 45);
    check_val("hm_hours",   hours2,   1);
    check_val("hm_editing", editing2, 0);
    check_val("hm_field",   field2,   1);
    nxt_but = 0; step(); step();
    check_val("hm_commit_off",  commit2, 0);
    check_val("hm_field_stays", field2,  1);
    check_val("hm_commit_count", commits2 - base2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_setter.md
# time_setter

Clocked, parametrised time-entry block for the alarm clock. While the mode FSM's `state` equals `SET_STATE`, it preloads an edit copy of the time and lets the user select fields with the next button. Fields are written from the switch input or stepped with wrap-around. On completion it emits a one-cycle `commit` pulse so the timekeeper (or alarm register) loads `hours`/`minutes`/`seconds`. `NUM_FIELDS=2` gives an hours/minutes-only variant for alarm setting.

## Interface
- `SET_STATE`, 3'b010, mode-FSM encoding that enables editing
- `NUM_FIELDS`, 3, 3 = H/M/S; 2 = H/M only (seconds forced to 0 at commit)
- `HOUR_MAX`, 23, hour wrap limit, 1..31
- `MIN_MAX`, 59, minute wrap limit, 1..63
- `SEC_MAX`, 59, second wrap limit, 1..63
- `clk` input 1, system clock; all logic on rising edge
- `rst` input 1, synchronous, active-high reset
- `state` input 3, mode-FSM state
- `nxt_but` input 1, advance to next field (already debounced/synchronised, level)
- `load_but` input 1, write `in_time` into current field
- `inc_but` input 1, current field +1 with wrap
- `dec_but` input 1, current field −1 with wrap
- `in_time` input 6, switch value for load
- `cur_hours` input 5 / `cur_minutes` input 6 / `cur_seconds` input 6, running time, preloaded on entry
- `hours` output 5 / `minutes` output 6 / `seconds` output 6, edit registers
- `field` output 2, 0 = hours, 1 = minutes, 2 = seconds
- `editing` output 1, high in EDIT states
- `commit` output 1, one-cycle pulse: outputs hold the final value

## Operation
- All four buttons are rising-edge detected: `edge = btn & ~btn_q`, where `btn_q` is the previous-cycle sample. A held button acts once.
- FSM states: IDLE, EDIT, DONE.
- IDLE -> EDIT when `state==SET_STATE`:
  - load `hours/minutes/seconds` from `cur_*`
  - set `field`=0, `editing`=1
- In EDIT, per cycle:
  - Edit action on the current field. Priority load > inc > dec; only one action applies.
  - Load: value = min(`in_time`, field MAX). The compare uses the full 6 bits, so `in_time`=40 on hours gives 23; no truncation.
  - Inc at MAX -> 0; dec at 0 -> MAX; otherwise ±1.
  - `nxt` edge in the same cycle: the edit applies to the old field first, then `field` advances.
  - When `field==NUM_FIELDS-1` and a `nxt` edge arrives -> DONE.
- Entering DONE:
  - `commit`=1 for exactly one cycle, `editing`=0
  - if `NUM_FIELDS==2`, `seconds` is written 0 on the same edge
- DONE -> IDLE only when `state!=SET_STATE`. Remaining in `SET_STATE` never re-enters EDIT and never re-commits.
- Abort: `state!=SET_STATE` while in EDIT:
  - -> IDLE, no `commit`, `editing`=0
  - edit registers keep their values
  - this takes priority over any button edge in that cycle
- IDLE ignores all buttons. Edit registers hold.

## Timing
- Reset (sync, `rst` high at an edge): FSM=IDLE; `hours`=0, `minutes`=0, `seconds`=0, `field`=0, `editing`=0, `commit`=0, all `btn_q`=0.
- `rst` overrides everything, including mid-edit. No `commit` is produced.
- Entry latency: `state` becomes `SET_STATE` before edge N -> at edge N, preload is done and `editing`=1.
  - Button edges sampled at edge N are ignored; editing starts at edge N+1.
- Button latency: button first high at edge N -> the field value or `field` update is visible after edge N (one-cycle registered response).
- Final `nxt` edge at edge N -> `commit`=1 during cycle N..N+1, deasserted at edge N+1. Outputs are stable from edge N onward.
- A button high before entry, or high across reset release, does not fire. Its `btn_q` already tracks 1, or `btn_q`=0 after reset combined with IDLE ignoring it.

## Test plan
- Reset: `rst`=1 one edge with garbage inputs -> all outputs 0, FSM IDLE. Hold `state`=3'b010 with no buttons -> `editing`=1, `hours/minutes/seconds` = `cur_*` (e.g. 12/34/56).
- Load/clamp: on hours, `in_time`=7 + load -> `hours`=7. `in_time`=40 + load -> 23. On minutes, `in_time`=63 -> 59.
- Wrap: hours=23 + inc -> 0. Minutes=0 + dec -> 59. Inc held 10 cycles -> exactly +1. Load+inc same cycle -> load wins.
- Full sequence, `NUM_FIELDS=3`: load 9, nxt, load 30, nxt, load 15, nxt -> single `commit` pulse with 9/30/15. Holding `state` 20 more cycles -> no further `commit`. Leave and re-enter -> preload again.
- Abort and simultaneity: `state` leaves 3'b010 mid-minutes with a nxt edge in the same cycle -> IDLE, `commit` never asserted, `field` unchanged. `rst` mid-edit -> all outputs 0.
- `NUM_FIELDS=2`: nxt from minutes -> `commit` with `seconds`=0, `field` never reaches 2.
